// File: rtl/sdpram_arbiter_if.sv
// Bundle of write/read client and RAM port signals for sdpram_arbiter.
`timescale 1ns/1ps
interface sdpram_arbiter_if #(
   parameter int DP = 512,
   parameter int DW = 8,
   parameter int AW = $clog2(DP)
);
   logic          w0_req;
   logic [AW-1:0] w0_addr;
   logic [DW-1:0] w0_data;
   logic          w0_gnt;
   logic          w1_req;
   logic [AW-1:0] w1_addr;
   logic [DW-1:0] w1_data;
   logic          w1_gnt;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_gnt;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_ready;
   logic          ram_cea;
   logic [AW-1:0] ram_addra;
   logic [DW-1:0] ram_dina;
   logic          ram_ceb;
   logic [AW-1:0] ram_addrb;
   logic [DW-1:0] ram_doutb;

   // clients plus the RAM instance
   modport master (
      output w0_req, w0_addr, w0_data,
      output w1_req, w1_addr, w1_data,
      output rd_req, rd_addr, rd_ready,
      output ram_doutb,
      input  w0_gnt, w1_gnt, rd_gnt,
      input  rd_valid, rd_data,
      input  ram_cea, ram_addra, ram_dina,
      input  ram_ceb, ram_addrb
   );

   // the arbiter itself
   modport slave (
      input  w0_req, w0_addr, w0_data,
      input  w1_req, w1_addr, w1_data,
      input  rd_req, rd_addr, rd_ready,
      input  ram_doutb,
      output w0_gnt, w1_gnt, rd_gnt,
      output rd_valid, rd_data,
      output ram_cea, ram_addra, ram_dina,
      output ram_ceb, ram_addrb
   );
endinterface

// File: rtl/sdpram_arbiter.sv
// Round-robin two-port write arbiter plus one-deep read response slot for an
// SDP RAM. Optional same-address read bypass: SDPRAM_ARB_RAW_BYPASS_EN.
`timescale 1ns/1ps
module sdpram_arbiter #(
   parameter int DP = 512,
   parameter int DW = 8,
   parameter int AW = $clog2(DP)
) (
   input logic             clk,
   input logic             rst,
   sdpram_arbiter_if.slave bus
);
   logic          last;
   logic          g0;
   logic          g1;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_gnt;
   logic          rd_valid;

   // grants are held low during reset so no write lands on a reset edge
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (!rst) begin
         unique case ({bus.w0_req, bus.w1_req})
            2'b10: g0 = 1'b1;
            2'b01: g1 = 1'b1;
            2'b11: begin
               g0 = last;
               g1 = !last;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= 1'b1;
      end else if (g0 | g1) begin
         last <= g1;
      end
   end

   assign wr_en   = g0 | g1;
   assign wr_addr = g1 ? bus.w1_addr : bus.w0_addr;
   assign wr_data = g1 ? bus.w1_data : bus.w0_data;

   assign bus.w0_gnt    = g0;
   assign bus.w1_gnt    = g1;
   assign bus.ram_cea   = wr_en;
   assign bus.ram_addra = wr_addr;
   assign bus.ram_dina  = wr_data;

   assign rd_gnt = !rst & bus.rd_req & (!rd_valid | bus.rd_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
      end else if (rd_gnt) begin
         rd_valid <= 1'b1;
      end else if (bus.rd_ready) begin
         rd_valid <= 1'b0;
      end
   end

   assign bus.rd_gnt    = rd_gnt;
   assign bus.rd_valid  = rd_valid;
   assign bus.ram_ceb   = rd_gnt;
   assign bus.ram_addrb = bus.rd_addr;

`ifdef SDPRAM_ARB_RAW_BYPASS_EN
   logic          hit;
   logic [DW-1:0] byp_data;

   // captured write stays paired with its response until the slot reloads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit      <= 1'b0;
         byp_data <= '0;
      end else if (rd_gnt) begin
         hit      <= wr_en && (wr_addr == bus.rd_addr);
         byp_data <= wr_data;
      end
   end

   assign bus.rd_data = hit ? byp_data : bus.ram_doutb;
`else
   assign bus.rd_data = bus.ram_doutb;
`endif
endmodule

// File: tb/tb_sdpram_arbiter.sv
// Randomised scoreboard bench for sdpram_arbiter with a behavioural RAM
// and a spec-level reference model of arbitration and read responses.
`timescale 1ns/1ps
module tb_sdpram_arbiter;
   localparam int DP = 512;
   localparam int DW = 8;
   localparam int AW = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sdpram_arbiter_if #(.DP(DP), .DW(DW), .AW(AW)) bus ();

   sdpram_arbiter #(.DP(DP), .DW(DW), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem     [DP];
   logic [DW-1:0] ref_mem [DP];
   logic [DW-1:0] sb [$];

   int tests = 0;
   int fails = 0;

   logic          ref_last  = 1'b1;
   logic          exp_valid = 1'b0;
   logic          e0, e1, er;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd, rd_exp;
   logic          g0s, g1s;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // RAM instance model: registered read returns pre-write contents
   always @(posedge clk) begin
      if (bus.ram_ceb) bus.ram_doutb <= mem[bus.ram_addrb];
      if (bus.ram_cea) mem[bus.ram_addra] <= bus.ram_dina;
   end

   // reference model: predicts grants, pushes expected read data
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_w0_gnt", bus.w0_gnt, 0);
         chk("rst_w1_gnt", bus.w1_gnt, 0);
         chk("rst_rd_gnt", bus.rd_gnt, 0);
         chk("rst_cea", bus.ram_cea, 0);
         chk("rst_ceb", bus.ram_ceb, 0);
         chk("rst_rd_valid", bus.rd_valid, 0);
         ref_last  = 1'b1;
         exp_valid = 1'b0;
      end else begin
         if (bus.w0_req && bus.w1_req) begin
            e0 = ref_last;
            e1 = !ref_last;
         end else begin
            e0 = bus.w0_req;
            e1 = bus.w1_req;
         end
         wa = e1 ? bus.w1_addr : bus.w0_addr;
         wd = e1 ? bus.w1_data : bus.w0_data;
         chk("w0_gnt", bus.w0_gnt, e0);
         chk("w1_gnt", bus.w1_gnt, e1);
         chk("ram_cea", bus.ram_cea, e0 | e1);
         if (e0 | e1) begin
            chk("ram_addra", bus.ram_addra, wa);
            chk("ram_dina", bus.ram_dina, wd);
         end
         er = bus.rd_req && (!exp_valid || bus.rd_ready);
         chk("rd_gnt", bus.rd_gnt, er);
         chk("ram_ceb", bus.ram_ceb, er);
         chk("rd_valid", bus.rd_valid, exp_valid);
         if (er) begin
            chk("ram_addrb", bus.ram_addrb, bus.rd_addr);
            rd_exp = ref_mem[bus.rd_addr];
`ifdef SDPRAM_ARB_RAW_BYPASS_EN
            if ((e0 | e1) && wa == bus.rd_addr) rd_exp = wd;
`endif
            sb.push_back(rd_exp);
         end
         if (e0 | e1) begin
            ref_mem[wa] = wd;
            ref_last    = e1;
         end
         if (er) exp_valid = 1'b1;
         else if (bus.rd_ready) exp_valid = 1'b0;
      end
   end

   // monitor: compares every presented response, pops on consumption
   always @(negedge clk) begin
      if (!rst && bus.rd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_unexpected: got rd_valid=1 expected no response");
         end else begin
            chk("rd_data", bus.rd_data, sb[0]);
            if (bus.rd_ready) void'(sb.pop_front());
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      bus.w0_req   = 1'b0;
      bus.w1_req   = 1'b0;
      bus.rd_req   = 1'b0;
      bus.rd_ready = 1'b1;
   endtask

   task automatic w0(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.w0_req  = 1'b1;
      bus.w0_addr = a;
      bus.w0_data = d;
   endtask

   initial begin
      for (int i = 0; i < DP; i++) begin
         mem[i]     = DW'(i * 7 + 3);
         ref_mem[i] = DW'(i * 7 + 3);
      end
      bus.w0_addr = '0;
      bus.w0_data = '0;
      bus.w1_addr = '0;
      bus.w1_data = '0;
      bus.rd_addr = '0;
      bus.ram_doutb = '0;
      idle();
      step(3);
      rst = 1'b0;
      step(1);

      // both writers contend continuously; w0 must win first
      w0(9'h010, 8'hA1);
      bus.w1_req  = 1'b1;
      bus.w1_addr = 9'h020;
      bus.w1_data = 8'hB2;
      #1;
      chk("first_contention_w0", bus.w0_gnt, 1);
      step(6);
      idle();
      step(1);

      // single writer then read back
      bus.w1_req  = 1'b1;
      bus.w1_addr = 9'h005;
      bus.w1_data = 8'h33;
      step(1);
      idle();
      bus.rd_req   = 1'b1;
      bus.rd_addr  = 9'h005;
      bus.rd_ready = 1'b0;
      step(1);
      chk("read_05_valid", bus.rd_valid, 1);
      chk("read_05_data", bus.rd_data, 8'h33);

      // back-pressure with next request held
      bus.rd_addr = 9'h006;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_rd_gnt", bus.rd_gnt, 0);
         chk("stall_rd_data", bus.rd_data, 8'h33);
         step(1);
      end
      bus.rd_ready = 1'b1;
      #1;
      chk("release_rd_gnt", bus.rd_gnt, 1);
      step(1);
      chk("release_rd_valid", bus.rd_valid, 1);
      idle();
      step(2);

      // fill 0..7 then stream reads
      for (int i = 0; i < 8; i++) begin
         w0(AW'(i), 8'($urandom));
         step(1);
      end
      idle();
      for (int i = 0; i < 8; i++) begin
         bus.rd_req  = 1'b1;
         bus.rd_addr = AW'(i);
         step(1);
      end
      idle();
      step(2);

      // same-edge write/read collision
      w0(9'h008, 8'h11);
      step(1);
      w0(9'h008, 8'h99);
      bus.rd_req  = 1'b1;
      bus.rd_addr = 9'h008;
      step(1);
      idle();
`ifdef SDPRAM_ARB_RAW_BYPASS_EN
      chk("collision_data", bus.rd_data, 8'h99);
`else
      chk("collision_data", bus.rd_data, 8'h11);
`endif
      step(1);

      // randomised traffic honouring the hold-until-granted rule
      g0s = 1'b0;
      g1s = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!(bus.w0_req && !g0s)) begin
            bus.w0_req  = 1'($urandom_range(0, 1));
            bus.w0_addr = AW'($urandom_range(0, 15));
            bus.w0_data = 8'($urandom);
         end
         if (!(bus.w1_req && !g1s)) begin
            bus.w1_req  = 1'($urandom_range(0, 1));
            bus.w1_addr = AW'($urandom_range(0, 15));
            bus.w1_data = 8'($urandom);
         end
         bus.rd_req   = 1'($urandom_range(0, 1));
         bus.rd_addr  = AW'($urandom_range(0, 15));
         bus.rd_ready = ($urandom_range(0, 3) != 0);
         #2;
         g0s = bus.w0_gnt;
         g1s = bus.w1_gnt;
         step(1);
      end
      idle();
      step(3);

      // async reset while a response is stalled
      bus.rd_req   = 1'b1;
      bus.rd_addr  = 9'h003;
      bus.rd_ready = 1'b0;
      step(1);
      bus.rd_req = 1'b0;
      chk("pre_reset_valid", bus.rd_valid, 1);
      rst = 1'b1;
      sb.delete();
      #1;
      chk("async_reset_valid", bus.rd_valid, 0);
      step(2);
      rst = 1'b0;
      idle();
      w0(9'h030, 8'h5A);
      bus.w1_req  = 1'b1;
      bus.w1_addr = 9'h031;
      bus.w1_data = 8'hA5;
      #1;
      chk("post_reset_w0_first", bus.w0_gnt, 1);
      step(4);
      idle();
      step(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
